vga_timing_generator: RTL
=========================

# vga_timing_generator

Parametrised VGA raster timing generator that replaces the fixed-threshold VGA controller. Horizontal and vertical timing come from explicit active/front-porch/sync/back-porch parameters, with selectable sync polarity and a pixel-clock enable. It also provides pixel coordinates, an active-video flag, and line/frame start strobes. It sits between the clock/reset logic and the pixel/framebuffer path and drives the VGA connector syncs directly.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BACK, 160, horizontal back porch (pixels); H_TOTAL = sum of the four H parameters = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 29, vertical back porch (lines); V_TOTAL = sum of the four V parameters = 806
- H_SYNC_POL, 0, h_sync asserted level (0 = active-low)
- V_SYNC_POL, 0, v_sync asserted level (0 = active-low)
- COUNTER_SIZE, 11, width of the internal counters and pixel_x/pixel_y; must hold H_TOTAL-1 and V_TOTAL-1
- control_clock  in  1  system clock; all logic on the rising edge
- control_reset_n  in  1  synchronous, active-low reset
- pixel_enable  in  1  pixel tick; timing advances only on clocks where this is 1
- h_sync  out  1  horizontal sync, at the level set by H_SYNC_POL when asserted
- v_sync  out  1  vertical sync, at the level set by V_SYNC_POL when asserted
- active_video  out  1  current pixel is inside the visible area
- pixel_x  out  COUNTER_SIZE  horizontal position while active_video is 1; 0 otherwise
- pixel_y  out  COUNTER_SIZE  vertical position while active_video is 1; 0 otherwise
- line_start  out  1  one-clock strobe: h_count just became 0
- frame_start  out  1  one-clock strobe: (h_count, v_count) just became (0, 0)

## Operation
- Internal h_count runs 0..H_TOTAL-1. On a clock with pixel_enable=1 it increments, and wraps to 0 after H_TOTAL-1.
- Internal v_count runs 0..V_TOTAL-1. It increments only on an enabled clock where h_count wraps, and wraps to 0 after V_TOTAL-1.
- Horizontal regions, in order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), back porch.
- Vertical regions follow the same ordering using the V parameters.
- h_sync = H_SYNC_POL while h_count is in the sync region, ~H_SYNC_POL otherwise. v_sync follows the same rule with v_count and V_SYNC_POL.
- active_video = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Reset (control_reset_n=0 on a clock edge) forces:
  - h_count=H_TOTAL-1 and v_count=V_TOTAL-1 (the back-porch corner), so the first enabled tick enters pixel (0,0);
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL;
  - active_video=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0.
- Reset takes priority over pixel_enable.
- Reset mid-frame abandons the frame immediately; no partial sync pulse is stretched.
- pixel_enable=0: counters and all level outputs hold their values; line_start and frame_start drop to 0.
- Every wrap of h_count asserts line_start. When h_count and v_count wrap together, line_start and frame_start assert in the same cycle.

## Timing
- All outputs are registers, loaded on the same edge that updates the counters. They are decoded from the post-edge counter values, so there is zero skew between any output and the counter state.
- Latency is one control_clock from an enabled edge to the outputs reflecting the new position.
- Strobes are exactly one control_clock wide, even when pixel_enable stays 1.
- h_sync period is H_TOTAL enabled ticks. v_sync asserts for exactly V_SYNC lines = V_SYNC*H_TOTAL enabled ticks, with edges coincident with line_start.
- The frame period is H_TOTAL*V_TOTAL enabled ticks.

## Test plan
- Small parameters H=8/2/3/3 and V=4/1/2/1, COUNTER_SIZE=5, pixel_enable=1; hold reset 3 clocks:
  - during reset: h_sync=1, v_sync=1, active_video=0, pixel_x=0, pixel_y=0, strobes 0;
  - first clock after release: frame_start=1, line_start=1, active_video=1, pixel_x=0, pixel_y=0.
- Same bench, horizontal check:
  - active_video high for pixel_x 0..7;
  - h_sync low exactly while h_count is 10..12 (3 clocks);
  - line_start every 16 clocks.
- Same bench, vertical check:
  - v_sync low for lines 5..6 (32 clocks), its falling edge coincident with line_start;
  - frame_start every 128 clocks, with pixel_y reaching 3 and returning to 0.
- pixel_enable toggling 1,0,1,0:
  - levels hold during disabled clocks;
  - strobes remain 1 clock wide;
  - frame_start period = 256 clocks.
- Assert reset for 1 clock at pixel (5,2), then release:
  - outputs return to their reset values;
  - next enabled clock gives frame_start=1 and pixel (0,0).
- Default parameters with H_SYNC_POL=1:
  - h_sync high for 136 ticks per 1344;
  - v_sync (POL=0) low for 6*1344=8064 ticks;
  - frame_start period 1083264 ticks.

Source files
------------

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster timing: h/v counters with registered syncs, active flag,
// pixel coordinates and line/frame strobes, all decoded from the post-edge position.
module vga_timing_generator #(
    parameter int H_ACTIVE     = 1024,
    parameter int H_FRONT      = 24,
    parameter int H_SYNC       = 136,
    parameter int H_BACK       = 160,
    parameter int V_ACTIVE     = 768,
    parameter int V_FRONT      = 3,
    parameter int V_SYNC       = 6,
    parameter int V_BACK       = 29,
    parameter int H_SYNC_POL   = 0,
    parameter int V_SYNC_POL   = 0,
    parameter int COUNTER_SIZE = 11
) (
    input  logic                    control_clock,
    input  logic                    control_reset_n,
    input  logic                    pixel_enable,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    active_video,
    output logic [COUNTER_SIZE-1:0] pixel_x,
    output logic [COUNTER_SIZE-1:0] pixel_y,
    output logic                    line_start,
    output logic                    frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COUNTER_SIZE-1:0] H_LAST       = COUNTER_SIZE'(H_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] V_LAST       = COUNTER_SIZE'(V_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] H_ACT_END    = COUNTER_SIZE'(H_ACTIVE);
    localparam logic [COUNTER_SIZE-1:0] V_ACT_END    = COUNTER_SIZE'(V_ACTIVE);
    localparam logic [COUNTER_SIZE-1:0] H_SYNC_BEGIN = COUNTER_SIZE'(H_ACTIVE + H_FRONT);
    localparam logic [COUNTER_SIZE-1:0] H_SYNC_END   = COUNTER_SIZE'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COUNTER_SIZE-1:0] V_SYNC_BEGIN = COUNTER_SIZE'(V_ACTIVE + V_FRONT);
    localparam logic [COUNTER_SIZE-1:0] V_SYNC_END   = COUNTER_SIZE'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [COUNTER_SIZE-1:0] CNT_ONE      = COUNTER_SIZE'(1);
    localparam logic                    HS_ON        = 1'(H_SYNC_POL);
    localparam logic                    VS_ON        = 1'(V_SYNC_POL);

    logic [COUNTER_SIZE-1:0] h_count;
    logic [COUNTER_SIZE-1:0] v_count;
    logic [COUNTER_SIZE-1:0] h_next;
    logic [COUNTER_SIZE-1:0] v_next;
    logic                    h_wrap;
    logic                    v_wrap;
    logic                    active_next;
    logic                    hs_next;
    logic                    vs_next;

    // Outputs are decoded from the position the counters are about to take,
    // so registering them on the same edge keeps them aligned with the counters.
    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_wrap = (v_count == V_LAST);
        h_next = h_wrap ? '0 : h_count + CNT_ONE;
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_count + CNT_ONE;
        end
        active_next = (h_next < H_ACT_END) && (v_next < V_ACT_END);
        hs_next     = ((h_next >= H_SYNC_BEGIN) && (h_next < H_SYNC_END)) ? HS_ON : ~HS_ON;
        vs_next     = ((v_next >= V_SYNC_BEGIN) && (v_next < V_SYNC_END)) ? VS_ON : ~VS_ON;
    end

    // Reset parks at the back-porch corner so the first enabled tick lands on (0,0).
    always_ff @(posedge control_clock) begin
        if (!control_reset_n) begin
            h_count      <= H_LAST;
            v_count      <= V_LAST;
            h_sync       <= ~HS_ON;
            v_sync       <= ~VS_ON;
            active_video <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (pixel_enable) begin
            h_count      <= h_next;
            v_count      <= v_next;
            h_sync       <= hs_next;
            v_sync       <= vs_next;
            active_video <= active_next;
            pixel_x      <= active_next ? h_next : '0;
            pixel_y      <= active_next ? v_next : '0;
            line_start   <= h_wrap;
            frame_start  <= h_wrap && v_wrap;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end
    end

endmodule
